// File: rtl/wiscsc15_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wiscsc15_pkg
// Description : Shared opcode map, FSM state encodings and opcode classifiers
//               for the WISC-SC15 multi-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package wiscsc15_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned ST_W = 3;

  typedef logic [OP_W-1:0] opcode_t;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_HALT   = 3'd5;

  localparam opcode_t OP_ADD    = 4'b0000;
  localparam opcode_t OP_SUB    = 4'b0001;
  localparam opcode_t OP_XOR    = 4'b0010;
  localparam opcode_t OP_RED    = 4'b0011;
  localparam opcode_t OP_SLL    = 4'b0100;
  localparam opcode_t OP_SRA    = 4'b0101;
  localparam opcode_t OP_ROR    = 4'b0110;
  localparam opcode_t OP_PADDSB = 4'b0111;
  localparam opcode_t OP_LW     = 4'b1000;
  localparam opcode_t OP_SW     = 4'b1001;
  localparam opcode_t OP_LLB    = 4'b1010;
  localparam opcode_t OP_LHB    = 4'b1011;
  localparam opcode_t OP_B      = 4'b1100;
  localparam opcode_t OP_CALL   = 4'b1101;
  localparam opcode_t OP_RET    = 4'b1110;
  localparam opcode_t OP_HLT    = 4'b1111;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_CALL) || (op == OP_RET);
  endfunction

  // RET pops its return address from the stack, so it reads like LW.
  function automatic logic is_mem_read(input opcode_t op);
    return (op == OP_LW) || (op == OP_RET);
  endfunction

  function automatic logic is_mem_write(input opcode_t op);
    return (op == OP_SW) || (op == OP_CALL);
  endfunction

  function automatic logic is_wb_op(input opcode_t op);
    return (op[3] == 1'b0) || (op == OP_LLB) || (op == OP_LHB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wiscsc15_retire_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wiscsc15_retire_cnt
// Description : Free-running retired-instruction counter, wraps modulo 2^CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module wiscsc15_retire_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/wiscsc15_seq.sv
`default_nettype none
// ============================================================================
// Module      : wiscsc15_seq
// Description : Multi-cycle control sequencer for WISC-SC15 (FETCH/DECODE/
//               EXEC/MEM/WB/HALT) with a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wiscsc15_seq
  import wiscsc15_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dm_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel_off,
  output logic             dm_read,
  output logic             dm_write,
  output logic             rf_we,
  output logic             halted,
  output logic             retired,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [2:0]       state
);

  state_t r_state;
  state_t w_next_state;

  logic w_imem_req;
  logic w_ir_we;
  logic w_pc_we;
  logic w_pc_sel_off;
  logic w_dm_read;
  logic w_dm_write;
  logic w_rf_we;
  logic w_halted;
  logic w_retired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (imem_ack) begin
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next_state = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode == OP_B) begin
          w_next_state = ST_FETCH;
        end else if (is_mem_op(opcode)) begin
          w_next_state = ST_MEM;
        end else if (opcode == OP_HLT) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_MEM: begin
        // Non-memory opcodes cannot reach MEM; recover to FETCH if one does.
        if (!is_mem_op(opcode)) begin
          w_next_state = ST_FETCH;
        end else if (dm_ack) begin
          w_next_state = (opcode == OP_LW) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        w_next_state = ST_FETCH;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // Strobes are gated by rst so that requests drop the instant reset rises.
  always_comb begin
    w_imem_req   = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_sel_off = 1'b0;
    w_dm_read    = 1'b0;
    w_dm_write   = 1'b0;
    w_rf_we      = 1'b0;
    w_halted     = 1'b0;
    w_retired    = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          w_imem_req = 1'b1;
          w_ir_we    = imem_ack;
        end
        ST_DECODE: begin
          w_retired = (opcode == OP_HLT);
        end
        ST_EXEC: begin
          if (opcode == OP_B) begin
            w_pc_we      = 1'b1;
            w_pc_sel_off = br_taken;
            w_retired    = 1'b1;
          end
        end
        ST_MEM: begin
          w_dm_read  = is_mem_read(opcode);
          w_dm_write = is_mem_write(opcode);
          if (dm_ack && is_mem_op(opcode) && (opcode != OP_LW)) begin
            w_pc_we      = 1'b1;
            w_pc_sel_off = (opcode == OP_CALL) || (opcode == OP_RET);
            w_retired    = 1'b1;
          end
        end
        ST_WB: begin
          w_rf_we   = 1'b1;
          w_pc_we   = 1'b1;
          w_retired = 1'b1;
        end
        ST_HALT: begin
          w_halted = 1'b1;
        end
        default: begin
          w_halted = 1'b0;
        end
      endcase
    end
  end

  wiscsc15_retire_cnt #(
    .CNT_W (CNT_W)
  ) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_retired),
    .count (retire_cnt)
  );

  assign imem_req   = w_imem_req;
  assign ir_we      = w_ir_we;
  assign pc_we      = w_pc_we;
  assign pc_sel_off = w_pc_sel_off;
  assign dm_read    = w_dm_read;
  assign dm_write   = w_dm_write;
  assign rf_we      = w_rf_we;
  assign halted     = w_halted;
  assign retired    = w_retired;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_wiscsc15_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wiscsc15_seq
// Description : Directed self-checking bench for wiscsc15_seq (16-bit and
//               4-bit retire counter instances driven in lock-step).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wiscsc15_seq;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_B    = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       br_taken = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dm_ack = 1'b0;

  logic        imem_req, ir_we, pc_we, pc_sel_off, dm_read, dm_write, rf_we, halted, retired;
  logic [15:0] retire_cnt;
  logic [2:0]  state;

  logic        q_imem_req, q_ir_we, q_pc_we, q_pc_sel_off, q_dm_read, q_dm_write, q_rf_we;
  logic        q_halted, q_retired;
  logic [3:0]  q_cnt;
  logic [2:0]  q_state;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  // {state, imem_req, ir_we, rf_we, pc_we, pc_sel_off, dm_read, dm_write, retired, halted}
  wire [11:0] obs = {state, imem_req, ir_we, rf_we, pc_we, pc_sel_off,
                     dm_read, dm_write, retired, halted};

  wiscsc15_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .imem_ack(imem_ack), .dm_ack(dm_ack), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel_off(pc_sel_off), .dm_read(dm_read), .dm_write(dm_write),
    .rf_we(rf_we), .halted(halted), .retired(retired), .retire_cnt(retire_cnt),
    .state(state)
  );

  wiscsc15_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .imem_ack(imem_ack), .dm_ack(dm_ack), .imem_req(q_imem_req), .ir_we(q_ir_we),
    .pc_we(q_pc_we), .pc_sel_off(q_pc_sel_off), .dm_read(q_dm_read), .dm_write(q_dm_write),
    .rf_we(q_rf_we), .halted(q_halted), .retired(q_retired), .retire_cnt(q_cnt),
    .state(q_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] ev(input logic [2:0] st, input logic ireq, input logic irwe,
                                     input logic rfwe, input logic pcwe, input logic sel,
                                     input logic dmr, input logic dmw, input logic ret,
                                     input logic hlt);
    return {st, ireq, irwe, rfwe, pcwe, sel, dmr, dmw, ret, hlt};
  endfunction

  // Drive one cycle's inputs on the falling edge, then settle before sampling.
  task automatic step(input logic [3:0] op, input logic ia, input logic da, input logic br);
    @(negedge clk);
    opcode   = op;
    imem_ack = ia;
    dm_ack   = da;
    br_taken = br;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    imem_ack = 1'b1;
    #1;
    checks++;
    if (obs !== 12'd0 || retire_cnt !== 16'd0 || q_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: obs=%h cnt=%0d cnt4=%0d required obs=000 cnt=0 cnt4=0",
               obs, retire_cnt, q_cnt);
    end
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    #1;
    checks++;
    if (obs !== ev(3'd0,1,0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_release: obs=%h required %h", obs, ev(3'd0,1,0,0,0,0,0,0,0,0));
    end
    exp_cnt = 0;
  endtask

  task automatic test_add();
    logic [11:0] exp_v [4];
    exp_v[0] = ev(3'd0,1,1,0,0,0,0,0,0,0);
    exp_v[1] = ev(3'd1,0,0,0,0,0,0,0,0,0);
    exp_v[2] = ev(3'd2,0,0,0,0,0,0,0,0,0);
    exp_v[3] = ev(3'd4,0,0,1,1,0,0,0,1,0);
    for (int i = 0; i < 4; i++) begin
      step(OP_ADD, 1'b1, 1'b1, 1'b0);
      if (i == 0) begin
        checks++;
        if (retire_cnt !== 16'(exp_cnt) || q_cnt !== 4'(exp_cnt)) begin
          errors++;
          $display("FAIL add_cnt: cnt=%0d cnt4=%0d required %0d / %0d",
                   retire_cnt, q_cnt, exp_cnt, exp_cnt % 16);
        end
      end
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL add_cycle%0d: obs=%h required %h", i + 1, obs, exp_v[i]);
      end
    end
    exp_cnt++;
  endtask

  task automatic test_lw_wait();
    logic [11:0] exp_v [8];
    int rd_cycles = 0;
    exp_v[0] = ev(3'd0,1,1,0,0,0,0,0,0,0);
    exp_v[1] = ev(3'd1,0,0,0,0,0,0,0,0,0);
    exp_v[2] = ev(3'd2,0,0,0,0,0,0,0,0,0);
    for (int i = 3; i < 7; i++) exp_v[i] = ev(3'd3,0,0,0,0,0,1,0,0,0);
    exp_v[7] = ev(3'd4,0,0,1,1,0,0,0,1,0);
    for (int i = 0; i < 8; i++) begin
      step(OP_LW, 1'b1, (i == 6), 1'b0);
      if (i == 0) begin
        checks++;
        if (retire_cnt !== 16'(exp_cnt)) begin
          errors++;
          $display("FAIL lw_cnt: cnt=%0d required %0d", retire_cnt, exp_cnt);
        end
      end
      if (dm_read === 1'b1) rd_cycles++;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL lw_cycle%0d: obs=%h required %h", i + 1, obs, exp_v[i]);
      end
    end
    checks++;
    if (rd_cycles != 4) begin
      errors++;
      $display("FAIL lw_read_len: dm_read cycles=%0d required 4", rd_cycles);
    end
    exp_cnt++;
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      logic tk;
      logic [11:0] exp_v [3];
      tk = (t == 0);
      exp_v[0] = ev(3'd0,1,1,0,0,0,0,0,0,0);
      exp_v[1] = ev(3'd1,0,0,0,0,0,0,0,0,0);
      exp_v[2] = ev(3'd2,0,0,0,1,tk,0,0,1,0);
      for (int i = 0; i < 3; i++) begin
        step(OP_B, 1'b1, 1'b0, tk);
        if (i == 0) begin
          checks++;
          if (retire_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL b_cnt: cnt=%0d required %0d", retire_cnt, exp_cnt);
          end
        end
        checks++;
        if (obs !== exp_v[i]) begin
          errors++;
          $display("FAIL b%0d_cycle%0d: obs=%h required %h", tk, i + 1, obs, exp_v[i]);
        end
      end
      exp_cnt++;
    end
  endtask

  task automatic test_call_ret();
    for (int t = 0; t < 2; t++) begin
      logic [3:0] op;
      logic [11:0] exp_v [4];
      op = (t == 0) ? OP_CALL : OP_RET;
      exp_v[0] = ev(3'd0,1,1,0,0,0,0,0,0,0);
      exp_v[1] = ev(3'd1,0,0,0,0,0,0,0,0,0);
      exp_v[2] = ev(3'd2,0,0,0,0,0,0,0,0,0);
      exp_v[3] = ev(3'd3,0,0,0,1,1,(t == 1),(t == 0),1,0);
      for (int i = 0; i < 4; i++) begin
        step(op, 1'b1, 1'b1, 1'b0);
        if (i == 0) begin
          checks++;
          if (retire_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL callret_cnt: cnt=%0d required %0d", retire_cnt, exp_cnt);
          end
        end
        checks++;
        if (obs !== exp_v[i]) begin
          errors++;
          $display("FAIL %s_cycle%0d: obs=%h required %h", (t == 0) ? "call" : "ret",
                   i + 1, obs, exp_v[i]);
        end
      end
      exp_cnt++;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [11:0] exp_v [5];
    exp_v[0] = ev(3'd0,1,1,0,0,0,0,0,0,0);
    exp_v[1] = ev(3'd1,0,0,0,0,0,0,0,0,0);
    exp_v[2] = ev(3'd2,0,0,0,0,0,0,0,0,0);
    exp_v[3] = ev(3'd3,0,0,0,0,0,0,1,0,0);
    exp_v[4] = ev(3'd3,0,0,0,0,0,0,1,0,0);
    for (int i = 0; i < 5; i++) begin
      step(OP_SW, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL sw_cycle%0d: obs=%h required %h", i + 1, obs, exp_v[i]);
      end
    end
    // Reset mid-MEM with an ack arriving at the same time.
    rst    = 1'b1;
    dm_ack = 1'b1;
    #1;
    checks++;
    if (obs !== 12'd0 || retire_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sw_rst_async: obs=%h cnt=%0d required obs=000 cnt=0", obs, retire_cnt);
    end
    step(OP_SW, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== 12'd0) begin
      errors++;
      $display("FAIL sw_rst_hold: obs=%h required 000", obs);
    end
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    dm_ack   = 1'b0;
    #1;
    checks++;
    if (obs !== ev(3'd0,1,0,0,0,0,0,0,0,0) || retire_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sw_rst_release: obs=%h cnt=%0d required %h cnt=0",
               obs, retire_cnt, ev(3'd0,1,0,0,0,0,0,0,0,0));
    end
    exp_cnt = 0;
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 17; n++) test_add();
    step(OP_ADD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (retire_cnt !== 16'd17 || q_cnt !== 4'd1 || state !== 3'd0) begin
      errors++;
      $display("FAIL wrap: cnt=%0d cnt4=%0d state=%0d required 17 / 1 / 0",
               retire_cnt, q_cnt, state);
    end
  endtask

  task automatic test_halt();
    step(OP_HLT, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== ev(3'd0,1,1,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL hlt_fetch: obs=%h required %h", obs, ev(3'd0,1,1,0,0,0,0,0,0,0));
    end
    step(OP_HLT, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== ev(3'd1,0,0,0,0,0,0,0,1,0)) begin
      errors++;
      $display("FAIL hlt_decode: obs=%h required %h", obs, ev(3'd1,0,0,0,0,0,0,0,1,0));
    end
    for (int i = 0; i < 20; i++) begin
      step(OP_HLT, i[0], i[0], 1'b0);
      checks++;
      if (obs !== ev(3'd5,0,0,0,0,0,0,0,0,1)) begin
        errors++;
        $display("FAIL hlt_cycle%0d: obs=%h required %h", i, obs, ev(3'd5,0,0,0,0,0,0,0,0,1));
      end
    end
    checks++;
    if (retire_cnt !== 16'(exp_cnt + 1) || q_cnt !== 4'(exp_cnt + 1)) begin
      errors++;
      $display("FAIL hlt_cnt: cnt=%0d cnt4=%0d required %0d / %0d",
               retire_cnt, q_cnt, exp_cnt + 1, (exp_cnt + 1) % 16);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_call_ret();
    test_reset_mid_mem();
    test_wrap();
    exp_cnt = 17;
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wiscsc15_seq.md
WISCSC15_SEQ -- requirements
Module: wiscsc15_seq

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 opcode  input  4  IR[15:12] of the current instruction, valid from DECODE onward.
REQ-005 br_taken  input  1  branch condition result from flag logic, sampled in EXEC.
REQ-006 imem_ack  input  1  instruction memory data valid.
REQ-007 dm_ack  input  1  data memory read data valid or write accepted.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 ir_we  output  1  instruction register load strobe.
REQ-010 pc_we  output  1  PC update strobe.
REQ-011 pc_sel_off  output  1  PC source select: 1 = offset/target, 0 = PC+1.
REQ-012 dm_read  output  1  data memory read request.
REQ-013 dm_write  output  1  data memory write request.
REQ-014 rf_we  output  1  register file write strobe.
REQ-015 halted  output  1  processor halted.
REQ-016 retired  output  1  one-cycle pulse on instruction completion.
REQ-017 retire_cnt  output  CNT_W  count of retired instructions.
REQ-018 state  output  3  current FSM state encoding.

Function
REQ-019 The FSM SHALL have six states with fixed encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-020 FETCH SHALL hold imem_req=1 until imem_ack; in the ack cycle it SHALL assert ir_we=1 and go to DECODE. An ack that arrives while imem_req=0 SHALL be ignored.
REQ-021 DECODE SHALL go to HALT for opcode 1111 and to EXEC for every other opcode.
REQ-022 From EXEC, ALU and immediate ops (0000-0111, 1010, 1011) SHALL go to WB, and LW (1000), SW (1001), CALL (1101) and RET (1110) SHALL go to MEM.
REQ-023 B (1100) in EXEC SHALL assert pc_we=1 and pc_sel_off=br_taken, retire, and go to FETCH.
REQ-024 MEM SHALL hold dm_read=1 for LW and RET, and dm_write=1 for SW and CALL, until dm_ack with no timeout.
REQ-025 On dm_ack, LW SHALL go to WB.
REQ-026 On dm_ack, SW SHALL assert pc_we (pc_sel_off=0), retire, and go to FETCH.
REQ-027 On dm_ack, CALL and RET SHALL assert pc_we with pc_sel_off=1, retire, and go to FETCH.
REQ-028 WB SHALL assert rf_we=1 and pc_we=1 (pc_sel_off=0) for exactly one cycle, retire, and go to FETCH.
REQ-029 dm_read and dm_write SHALL never be high in the same cycle.
REQ-030 rf_we SHALL be high only in WB, and ir_we only in FETCH.
REQ-031 HALT SHALL be absorbing until rst and SHALL drive halted=1 with all strobes 0; HLT SHALL increment the retire count once on entry.
REQ-032 retired SHALL pulse in the completion cycle, and retire_cnt SHALL increment by 1 at the following edge, wrapping modulo 2^CNT_W.
REQ-033 Latency with zero-wait acks SHALL be: ALU 4 cycles, B 3, SW 4, CALL 4, RET 4, LW 5; each wait cycle adds 1.
REQ-034 All strobes SHALL be decoded combinationally from the registered state and opcode, with no output registers.

Reset
REQ-035 While rst=1, state SHALL be FETCH, retire_cnt 0, and all strobes and halted 0, with imem_req forced to 0.
REQ-036 Reset asserted mid-MEM or mid-FETCH SHALL drop dm_read, dm_write and imem_req immediately (asynchronously), and a pending ack SHALL be discarded.
REQ-037 On the first rising edge after rst falls, imem_req SHALL be 1.

Structure
REQ-038 Shared package wiscsc15_pkg SHALL hold the 16 opcode constants and the state encodings; wiscsc15_ctrl SHALL use the same package.
REQ-039 The retire counter SHALL be a sub-module wiscsc15_retire_cnt (inputs clk, rst, inc, CNT_W parameter), and the FSM SHALL stay in this module.

Verification
REQ-040 ADD, acks held at 1: FETCH -> DECODE -> EXEC -> WB; rf_we=1 in cycle 4 only; retire_cnt goes 0 -> 1.
REQ-041 LW with dm_ack delayed 3 cycles: dm_read high for 4 cycles; WB in cycle 8; dm_write always 0.
REQ-042 B with br_taken=1, then B with br_taken=0: pc_we=1 in EXEC both times; pc_sel_off 1 then 0; rf_we never 1.
REQ-043 CALL then RET: dm_write then dm_read in MEM; pc_sel_off=1 on each ack; retire_cnt +2.
REQ-044 HLT: state goes 5 and stays 5 for 20 cycles with imem_ack toggling; halted=1; retire_cnt +1 only.
REQ-045 rst pulsed mid-MEM of SW, then CNT_W=4 with 17 ADDs: dm_write drops in the rst cycle and state=0 with imem_req=1 after rst; retire_cnt wraps to 1.
